// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-aligned load/store stage with memory request/ready handshake
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being forced aligned.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       storeData,
    output logic              busy,
    output logic              done,
    output logic [31:0]       loadData,
    output logic              fault,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    output logic [3:0]        memBe,
    input  logic              memReady,
    input  logic [31:0]       memRdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [1:0]      off_r;
    logic            we_r;
    logic            fault_r;
    logic [CW-1:0]   cnt;

    logic            is_byte, is_half;
    logic [1:0]      eff_off;
    logic [3:0]      be_in;
    logic [31:0]     wdata_in;
    logic            single, both, trap, timed_out;
    logic            unused;

    assign unused  = funct3[2];
    assign is_byte = (funct3[1:0] == 2'b00);
    assign is_half = (funct3[1:0] == 2'b01);
    assign single  = memRead ^ memWrite;
    assign both    = memRead & memWrite;

    // Offsets below the access size are dropped so untrapped misaligned accesses land aligned.
    always_comb begin
        eff_off  = 2'b00;
        be_in    = 4'b1111;
        wdata_in = storeData;
        if (is_byte) begin
            eff_off  = addr[1:0];
            be_in    = 4'b0001 << addr[1:0];
            wdata_in = {4{storeData[7:0]}};
        end else if (is_half) begin
            eff_off  = {addr[1], 1'b0};
            be_in    = 4'b0011 << {addr[1], 1'b0};
            wdata_in = {2{storeData[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = (is_half & addr[0]) | (funct3[1] & (addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign timed_out = (TIMEOUT > 0) && !memReady && (cnt == TLAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (single)
                    state_nx = trap ? RESP : ACCESS;
                else if (both)
                    state_nx = RESP;
            end
            ACCESS: begin
                if (memReady || timed_out)
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            off_r    <= 2'b00;
            we_r     <= 1'b0;
            fault_r  <= 1'b0;
            cnt      <= '0;
            loadData <= 32'h0;
            memAddr  <= '0;
            memWdata <= 32'h0;
            memBe    <= 4'b0000;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (single) begin
                        we_r     <= memWrite;
                        off_r    <= eff_off;
                        memAddr  <= {addr[ADDR_W-1:2], 2'b00};
                        memWdata <= wdata_in;
                        memBe    <= memWrite ? be_in : 4'b0000;
                        cnt      <= '0;
                        fault_r  <= trap;
                        if (trap && memRead)
                            loadData <= 32'h0;
                    end else if (both) begin
                        fault_r <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (memReady) begin
                        fault_r <= 1'b0;
                        if (!we_r)
                            loadData <= memRdata >> {off_r, 3'b000};
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timed_out) begin
                            fault_r <= 1'b1;
                            if (!we_r)
                                loadData <= 32'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign memReq = (state == ACCESS);
    assign memWe  = (state == ACCESS) & we_r;
    assign done   = (state == RESP);
    assign fault  = (state == RESP) & fault_r;
    assign busy   = (state == ACCESS) | ((state == IDLE) & (memRead | memWrite));

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, storeData;
    logic        busy, done, fault, memReq, memWe, memReady;
    logic [31:0] loadData, memAddr, memWdata, memRdata;
    logic [3:0]  memBe;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_ld = 32'h0;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .funct3(funct3), .addr(addr), .storeData(storeData), .busy(busy),
        .done(done), .loadData(loadData), .fault(fault), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
        .memReady(memReady), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction from request to return to IDLE, with expectations from the access rules.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int waits, input logic [31:0] rdata);
        int          size, off, nacc;
        bit          mis, trap, tmo;
        logic [3:0]  be;
        logic [31:0] wd;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = (a % 4) / size * size;
        mis  = (a % size) != 0 && size > 1;
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        be = (size == 4) ? 4'hF : ((size == 2) ? 4'h3 : 4'h1) << off;
        if (size == 1)      wd = sd[7:0] * 32'h01010101;
        else if (size == 2) wd = sd[15:0] * 32'h00010001;
        else                wd = sd;
        tmo  = waits >= TO;
        nacc = tmo ? TO : waits + 1;

        memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd; memReady = 1'b0;
        #1;
        check("busy_req", busy, rd | wr);
        check("req_idle", memReq, 1'b0);
        tick;
        memRead = 1'b0; memWrite = 1'b0;
        if ((rd && wr) || trap) begin
            if (trap && rd) model_ld = 32'h0;
            check("done_fault", done, 1'b1);
            check("fault_pulse", fault, 1'b1);
            check("req_nofault", memReq, 1'b0);
            check("ld_fault", loadData, model_ld);
            tick;
            check("done_clear", done, 1'b0);
            return;
        end
        for (int k = 0; k < nacc; k++) begin
            memReady = (k == waits);
            memRdata = (k == waits) ? rdata : $urandom;
            #1;
            check("memReq", memReq, 1'b1);
            check("busy_acc", busy, 1'b1);
            check("done_acc", done, 1'b0);
            check("memAddr", memAddr, a & 32'hFFFF_FFFC);
            check("memWe", memWe, wr);
            check("memBe", memBe, wr ? be : 4'h0);
            if (wr) check("memWdata", memWdata, wd);
            tick;
        end
        memReady = 1'b0;
        if (rd) model_ld = tmo ? 32'h0 : rdata >> (8 * off);
        check("done", done, 1'b1);
        check("fault", fault, tmo);
        check("loadData", loadData, model_ld);
        check("req_resp", memReq, 1'b0);
        check("busy_resp", busy, 1'b0);
        tick;
        check("done_idle", done, 1'b0);
    endtask

    initial begin
        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b0;
        addr = 32'h0; storeData = 32'h0; memReady = 1'b0; memRdata = 32'h0;
        tick; tick;
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_req", memReq, 1'b0);
        check("rst_ld", loadData, 32'h0);
        check("rst_be", memBe, 4'h0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick;

        run(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'hAABBCCDD);
        check("lb_0x103", loadData, 32'h000000AA);
        run(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 3, 32'h0);
        check("sh_keeps_ld", loadData, 32'h000000AA);
        run(1, 0, 3'b010, 32'h40, 32'h0, 100, 32'h0);
        run(1, 0, 3'b001, 32'h01, 32'h0, 1, 32'h89AB4321);
        run(1, 1, 3'b010, 32'h80, 32'h0, 0, 32'h0);

        // Reset while a read is waiting on memory.
        memRead = 1'b1; funct3 = 3'b010; addr = 32'h200;
        tick;
        memRead = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        check("rstacc_req", memReq, 1'b0);
        check("rstacc_busy", busy, 1'b0);
        check("rstacc_done", done, 1'b0);
        check("rstacc_ld", loadData, 32'h0);
        model_ld = 32'h0;
        reset = 1'b0;
        tick;

        for (int i = 0; i < 150; i++) begin
            int sel, w;
            sel = $urandom_range(0, 9);
            w   = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4);
            run(sel < 5 || sel == 9, sel >= 5, 3'($urandom), $urandom, $urandom, w, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
